my_mul: RTL and testbench
=========================

Name: my_mul

Overview:
- Parameterised integer multiplier: P = X × Y, full-width product of two WIDTH-bit operands, unsigned by default.
- Two-stage pipeline (partial-product stage, then final-sum stage) with a valid strobe travelling alongside the data.
- Feeds downstream datapath logic that consumes one product per cycle; no backpressure.

Parameters:
- WIDTH, 8, operand width in bits; must be even and ≥4; product width is 2*WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  x/y valid this cycle
- x  in  WIDTH  multiplicand
- y  in  WIDTH  multiplier
- out_valid  out  1  p holds a new product this cycle
- p  out  2*WIDTH  product

Behaviour:
- Reset: rst_n low asynchronously clears all pipeline registers; p=0, out_valid=0 while rst_n is low and after release until new data arrives.
- Stage 1, at the clock edge where in_valid=1:
  - lo_pp = x × y[WIDTH/2-1:0] (WIDTH+WIDTH/2 bits).
  - hi_pp = x × y[WIDTH-1:WIDTH/2].
  - Both are registered together with valid bit v1.
- Stage 2: p <= lo_pp + (hi_pp << WIDTH/2), out_valid <= v1.
- Latency: exactly 2 clocks from the sampling edge of in_valid to out_valid=1 with the matching p.
- Throughput: 1 product per clock; back-to-back in_valid accepted with no bubbles.
- When in_valid=0:
  - Stage-1 data registers hold their value; v1 <= 0.
  - p holds its last product; out_valid <= 0.
- Arithmetic: product is exact, no truncation, no overflow possible. Maximum is (2^WIDTH-1)^2, i.e. 65025 for WIDTH=8.
- Zero operand yields p=0.
- Reset mid-operation discards all in-flight products; no out_valid pulse is produced for them.
- x/y are don't-care when in_valid=0.

Optional Feature:
- Macro MY_MUL_SIGNED_EN.
- Defined: x and y are two's-complement, and p is the signed 2*WIDTH-bit product.
  - Sign-extend x.
  - Treat the low half of y as unsigned.
  - Treat the high half of y as signed.
  - Same latency, throughput and reset behaviour as the unsigned build.
- Undefined: fully unsigned behaviour as specified above.

Decomposition:
- Package my_mul_pkg:
  - Default WIDTH constant.
  - Derived localparam helpers: HALF = WIDTH/2, PW = 2*WIDTH.
  - Typedef for the stage-1 register bundle: lo_pp, hi_pp, v1.
- One sub-module, my_mul_pp: combinational WIDTH × HALF partial-product generator, built as a shift-and-add array with a signed-high-half option. It is instantiated twice, once for lo_pp and once for hi_pp.
- The top level holds the pipeline registers, the valid pipe and the final adder.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1, x=5, y=5 → p=0, out_valid=0. Release reset → first out_valid appears 2 clocks after the first sampled in_valid.
- Unsigned corners, WIDTH=8, one operand pair per cycle:
  - 255×255 → 65025.
  - 0×200 → 0.
  - 1×255 → 255.
- Back-to-back stream 7×11, 123×246, 55×88, 99×66, 77×22, 168×195 → out_valid high 6 consecutive cycles, p = 77, 30258, 4840, 6534, 1694, 32760 in that order.
- Gaps: in_valid pattern 1,0,1 with 10×10 then 3×4 → out_valid pattern 1,0,1 with p=100, then p held at 100, then p=12.
- Mid-flight reset: assert rst_n=0 one clock after accepting 200×200 → no out_valid pulse, p=0.
- With MY_MUL_SIGNED_EN:
  - 255×255 (−1×−1) → p=0x0001.
  - 128×2 → p=0xFF00 (−256).
  - 127×127 → 16129.

Source files
------------

// File: rtl/my_mul_pkg.sv
// my_mul_pkg: shared constants, width helpers and the stage-1 register
// bundle type for the my_mul pipelined multiplier.
//   MY_MUL_WIDTH  default operand width
//   half_w/prod_w derive HALF = WIDTH/2 and PW = 2*WIDTH
//   s1_bundle_t   stage-1 register bundle at the default width
package my_mul_pkg;

  localparam int unsigned MY_MUL_WIDTH = 8;

  function automatic int unsigned half_w(input int unsigned w);
    return w / 2;
  endfunction

  function automatic int unsigned prod_w(input int unsigned w);
    return 2 * w;
  endfunction

  localparam int unsigned MY_MUL_HALF = half_w(MY_MUL_WIDTH);
  localparam int unsigned MY_MUL_PW   = prod_w(MY_MUL_WIDTH);

  typedef struct packed {
    logic [MY_MUL_WIDTH+MY_MUL_HALF-1:0] lo_pp;
    logic [MY_MUL_WIDTH+MY_MUL_HALF-1:0] hi_pp;
    logic                                v1;
  } s1_bundle_t;

endpackage

// File: rtl/my_mul_pp.sv
// my_mul_pp: combinational WIDTH x WIDTH/2 partial-product generator,
// built as a shift-and-add array.
//   x  [WIDTH-1:0]          multiplicand (sign-extended when X_SIGNED)
//   y  [WIDTH/2-1:0]        multiplier half (MSB weighs negative when Y_SIGNED)
//   pp [WIDTH+WIDTH/2-1:0]  product; exact in both signed and unsigned modes
module my_mul_pp
  import my_mul_pkg::*;
#(
  parameter int unsigned WIDTH    = MY_MUL_WIDTH,
  parameter bit          X_SIGNED = 1'b0,
  parameter bit          Y_SIGNED = 1'b0
) (
  input  logic [WIDTH-1:0]         x,
  input  logic [WIDTH/2-1:0]       y,
  output logic [WIDTH+WIDTH/2-1:0] pp
);

  localparam int unsigned HALF = half_w(WIDTH);
  localparam int unsigned PPW  = WIDTH + HALF;

  logic [PPW-1:0] xe;
  logic [PPW-1:0] acc;

  always_comb begin
    xe  = {{HALF{X_SIGNED & x[WIDTH-1]}}, x};
    acc = '0;
    for (int unsigned i = 0; i < HALF; i++) begin
      if (y[i]) begin
        // In two's complement the multiplier MSB carries weight -2^(HALF-1),
        // so its row is subtracted instead of added.
        if (Y_SIGNED && (i == HALF - 1))
          acc = acc - (xe << i);
        else
          acc = acc + (xe << i);
      end
    end
    pp = acc;
  end

endmodule

// File: rtl/my_mul.sv
// my_mul: two-stage pipelined WIDTH x WIDTH multiplier, P = X * Y.
// Stage 1 registers the two partial products (low/high half of y), stage 2
// registers their aligned sum. Latency 2 clocks, one product per clock.
// Optional feature: define MY_MUL_SIGNED_EN for two's-complement operands
// and a signed product; otherwise fully unsigned.
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   x/y valid this cycle
//   x, y       WIDTH-bit operands
//   out_valid  p holds a new product this cycle
//   p          2*WIDTH-bit product (holds between products)
module my_mul
  import my_mul_pkg::*;
#(
  parameter int unsigned WIDTH = MY_MUL_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic               out_valid,
  output logic [2*WIDTH-1:0] p
);

  localparam int unsigned HALF = half_w(WIDTH);
  localparam int unsigned PW   = prod_w(WIDTH);
  localparam int unsigned PPW  = WIDTH + HALF;

`ifdef MY_MUL_SIGNED_EN
  localparam bit SIGNED_MODE = 1'b1;
`else
  localparam bit SIGNED_MODE = 1'b0;
`endif

  typedef struct packed {
    logic [PPW-1:0] lo_pp;
    logic [PPW-1:0] hi_pp;
    logic           v1;
  } s1_t;

  logic [PPW-1:0] lo_pp_c;
  logic [PPW-1:0] hi_pp_c;
  s1_t            s1_q;
  logic [PW-1:0]  lo_ext;
  logic [PW-1:0]  hi_ext;
  logic [PW-1:0]  sum_c;
  logic [PW-1:0]  p_q;
  logic           out_valid_q;

  // Low half of y is always an unsigned digit; only the high half carries sign.
  my_mul_pp #(
    .WIDTH    (WIDTH),
    .X_SIGNED (SIGNED_MODE),
    .Y_SIGNED (1'b0)
  ) u_pp_lo (
    .x  (x),
    .y  (y[HALF-1:0]),
    .pp (lo_pp_c)
  );

  my_mul_pp #(
    .WIDTH    (WIDTH),
    .X_SIGNED (SIGNED_MODE),
    .Y_SIGNED (SIGNED_MODE)
  ) u_pp_hi (
    .x  (x),
    .y  (y[WIDTH-1:HALF]),
    .pp (hi_pp_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
    end else begin
      s1_q.v1 <= in_valid;
      if (in_valid) begin
        s1_q.lo_pp <= lo_pp_c;
        s1_q.hi_pp <= hi_pp_c;
      end
    end
  end

  always_comb begin
    lo_ext = {{HALF{SIGNED_MODE & s1_q.lo_pp[PPW-1]}}, s1_q.lo_pp};
    hi_ext = {{HALF{SIGNED_MODE & s1_q.hi_pp[PPW-1]}}, s1_q.hi_pp};
    sum_c  = lo_ext + (hi_ext << HALF);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= s1_q.v1;
      if (s1_q.v1)
        p_q <= sum_c;
    end
  end

  assign p         = p_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_my_mul.sv
// tb_my_mul: directed, table-driven bench for my_mul at WIDTH=8.
// Expected products are hand-computed; the signed table is selected when
// MY_MUL_SIGNED_EN is defined.
module tb_my_mul;

  localparam int unsigned W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic [W-1:0]   x;
  logic [W-1:0]   y;
  logic           out_valid;
  logic [2*W-1:0] p;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic [2*W-1:0] exp;
  } vec_t;

  vec_t           vecs[10];
  vec_t           strm[6];

  always #5 clk = ~clk;

  my_mul #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .p         (p)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
`ifdef MY_MUL_SIGNED_EN
    vecs[0] = '{8'd255, 8'd255, 16'h0001};
    vecs[1] = '{8'd128, 8'd2,   16'hFF00};
    vecs[2] = '{8'd127, 8'd127, 16'd16129};
    vecs[3] = '{8'd0,   8'd200, 16'd0};
    vecs[4] = '{8'd1,   8'd255, 16'hFFFF};
    vecs[5] = '{8'd128, 8'd128, 16'd16384};
    vecs[6] = '{8'd200, 8'd0,   16'd0};
    vecs[7] = '{8'd15,  8'd17,  16'd255};
    vecs[8] = '{8'd240, 8'd15,  16'hFF10};
    vecs[9] = '{8'd170, 8'd85,  16'hE372};
    strm[0] = '{8'd7,   8'd11,  16'd77};
    strm[1] = '{8'd123, 8'd246, 16'd64306};
    strm[2] = '{8'd55,  8'd88,  16'd4840};
    strm[3] = '{8'd99,  8'd66,  16'd6534};
    strm[4] = '{8'd77,  8'd22,  16'd1694};
    strm[5] = '{8'd168, 8'd195, 16'd5368};
`else
    vecs[0] = '{8'd255, 8'd255, 16'd65025};
    vecs[1] = '{8'd0,   8'd200, 16'd0};
    vecs[2] = '{8'd1,   8'd255, 16'd255};
    vecs[3] = '{8'd128, 8'd2,   16'd256};
    vecs[4] = '{8'd127, 8'd127, 16'd16129};
    vecs[5] = '{8'd128, 8'd128, 16'd16384};
    vecs[6] = '{8'd200, 8'd0,   16'd0};
    vecs[7] = '{8'd15,  8'd17,  16'd255};
    vecs[8] = '{8'd240, 8'd15,  16'd3600};
    vecs[9] = '{8'd170, 8'd85,  16'd14450};
    strm[0] = '{8'd7,   8'd11,  16'd77};
    strm[1] = '{8'd123, 8'd246, 16'd30258};
    strm[2] = '{8'd55,  8'd88,  16'd4840};
    strm[3] = '{8'd99,  8'd66,  16'd6534};
    strm[4] = '{8'd77,  8'd22,  16'd1694};
    strm[5] = '{8'd168, 8'd195, 16'd32760};
`endif

    // Reset held with live inputs: outputs stay cleared.
    rst_n    = 1'b0;
    in_valid = 1'b1;
    x        = 8'd5;
    y        = 8'd5;
    #2;
    check("reset_p", 32'(p), 32'd0);
    check("reset_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_hold_p", 32'(p), 32'd0);
      check("reset_hold_valid", 32'(out_valid), 32'd0);
    end

    // Release: 5x5 sampled on the next edge, product one edge later.
    rst_n = 1'b1;
    tick();
    check("latency_first_edge_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b0;
    tick();
    check("latency_valid", 32'(out_valid), 32'd1);
    check("latency_p", 32'(p), 32'd25);
    tick();
    check("latency_valid_drop", 32'(out_valid), 32'd0);
    check("latency_p_hold", 32'(p), 32'd25);

    // Table of isolated operand pairs.
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      x        = vecs[i].x;
      y        = vecs[i].y;
      tick();
      check("vec_idle_valid", 32'(out_valid), 32'd0);
      in_valid = 1'b0;
      x        = W'($urandom);
      y        = W'($urandom);
      tick();
      check("vec_valid", 32'(out_valid), 32'd1);
      check($sformatf("vec%0d_p", i), 32'(p), 32'(vecs[i].exp));
      tick();
      check("vec_valid_drop", 32'(out_valid), 32'd0);
      check($sformatf("vec%0d_p_hold", i), 32'(p), 32'(vecs[i].exp));
    end

    // Back-to-back stream, no bubbles.
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1;
      x        = strm[k].x;
      y        = strm[k].y;
      tick();
      if (k == 0) begin
        check("stream_first_valid", 32'(out_valid), 32'd0);
      end else begin
        check("stream_valid", 32'(out_valid), 32'd1);
        check($sformatf("stream%0d_p", k - 1), 32'(p), 32'(strm[k-1].exp));
      end
    end
    in_valid = 1'b0;
    tick();
    check("stream_valid", 32'(out_valid), 32'd1);
    check("stream5_p", 32'(p), 32'(strm[5].exp));
    tick();
    check("stream_end_valid", 32'(out_valid), 32'd0);
    check("stream_end_p_hold", 32'(p), 32'(strm[5].exp));

    // Gap pattern 1,0,1 on in_valid.
    in_valid = 1'b1;
    x        = 8'd10;
    y        = 8'd10;
    tick();
    in_valid = 1'b0;
    x        = 8'd99;
    y        = 8'd99;
    tick();
    check("gap_valid_1", 32'(out_valid), 32'd1);
    check("gap_p_100", 32'(p), 32'd100);
    in_valid = 1'b1;
    x        = 8'd3;
    y        = 8'd4;
    tick();
    check("gap_valid_0", 32'(out_valid), 32'd0);
    check("gap_p_held", 32'(p), 32'd100);
    in_valid = 1'b0;
    tick();
    check("gap_valid_2", 32'(out_valid), 32'd1);
    check("gap_p_12", 32'(p), 32'd12);
    tick();
    check("gap_end_valid", 32'(out_valid), 32'd0);

    // Reset while 200x200 is in flight: product must be discarded.
    in_valid = 1'b1;
    x        = 8'd200;
    y        = 8'd200;
    tick();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("midreset_async_p", 32'(p), 32'd0);
    check("midreset_async_valid", 32'(out_valid), 32'd0);
    tick();
    check("midreset_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("midreset_after_valid", 32'(out_valid), 32'd0);
      check("midreset_after_p", 32'(p), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
